// File: rtl/rpspmc_cfg_pkg.sv
// Shared cfg-bus layout and state encoding for the rpspmc cfg-controlled AXIS stages.
package rpspmc_cfg_pkg;

    localparam int unsigned CFG_WORD_W = 32;
    localparam int unsigned SHIFT_LSB  = 0;
    localparam int unsigned SHIFT_W    = 4;
    localparam int unsigned EN_BIT     = 4;
    localparam int unsigned CLR_BIT    = 5;

    typedef enum logic [0:0] {
        IDLE,
        ACCUM
    } avg_state_e;

endpackage

// File: rtl/cfg_word_extract.sv
// Slices one cfg word, clamps the shift field and registers the fields one stage.
// Also flags the cycle in which the registered shift differs from its shadow copy.
module cfg_word_extract
    import rpspmc_cfg_pkg::*;
#(
    parameter int unsigned SRC_ADDR  = 0,
    parameter int unsigned CFG_WIDTH = 1024,
    parameter int unsigned MAX_SHIFT = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CFG_WIDTH-1:0] cfg_i,
    output logic [SHIFT_W-1:0]   shift_o,
    output logic                 en_o,
    output logic                 clr_o,
    output logic                 shift_chg_o
);

    localparam int unsigned WordLsb = SRC_ADDR * CFG_WORD_W;

    logic [SHIFT_W-1:0] shift_raw;
    logic [SHIFT_W-1:0] shift_clamped;
    logic [SHIFT_W-1:0] shift_q;
    logic [SHIFT_W-1:0] shift_sh_q;
    logic               en_q;
    logic               clr_q;
    logic               unused_cfg;

    // Only a few bits of the bus belong to this word; the rest is deliberately ignored.
    assign unused_cfg    = ^cfg_i;
    assign shift_raw     = cfg_i[WordLsb + SHIFT_LSB +: SHIFT_W];
    assign shift_clamped = (shift_raw > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : shift_raw;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q    <= '0;
            shift_sh_q <= '0;
            en_q       <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            shift_q    <= shift_clamped;
            shift_sh_q <= shift_q;
            en_q       <= cfg_i[WordLsb + EN_BIT];
            clr_q      <= cfg_i[WordLsb + CLR_BIT];
        end
    end

    assign shift_o     = shift_q;
    assign en_o        = en_q;
    assign clr_o       = clr_q;
    assign shift_chg_o = (shift_q != shift_sh_q);

endmodule

// File: rtl/cfg_axis_decimate_avg.sv
// Boxcar decimator: averages 2^shift valid samples of the selected stream into one mean,
// restarting the block whenever the upstream source or the block length changes.
module cfg_axis_decimate_avg
    import rpspmc_cfg_pkg::*;
#(
    parameter int unsigned SRC_ADDR         = 0,
    parameter int unsigned CFG_WIDTH        = 1024,
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned MAX_SHIFT        = 10,
    parameter int unsigned ACC_WIDTH        = 48
) (
    input  logic                        a_clk,
    input  logic                        a_rst,
    input  logic [CFG_WIDTH-1:0]        cfg,
    input  logic                        sel_status,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    output logic [15:0]                 blk_count
);

    localparam int unsigned W    = AXIS_TDATA_WIDTH;
    localparam int unsigned CntW = MAX_SHIFT + 1;

    logic [SHIFT_W-1:0] shift;
    logic               en;
    logic               clr;
    logic               shift_chg;

    cfg_word_extract #(
        .SRC_ADDR  (SRC_ADDR),
        .CFG_WIDTH (CFG_WIDTH),
        .MAX_SHIFT (MAX_SHIFT)
    ) u_cfg (
        .clk_i       (a_clk),
        .rst_i       (a_rst),
        .cfg_i       (cfg),
        .shift_o     (shift),
        .en_o        (en),
        .clr_o       (clr),
        .shift_chg_o (shift_chg)
    );

    avg_state_e                  state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [W-1:0]                tdata_q, tdata_d;
    logic                        tvalid_q, tvalid_d;
    logic [15:0]                 blk_q, blk_d;
    logic                        sel_q;

    logic signed [ACC_WIDTH-1:0] acc_in;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic signed [ACC_WIDTH-1:0] mean_full;
    logic [CntW-1:0]             cnt_inc;
    logic [CntW-1:0]             blk_len;
    logic                        active;
    logic                        restart;
    logic                        unused_mean_hi;

    assign acc_in    = {{(ACC_WIDTH-W){S_AXIS_tdata[W-1]}}, S_AXIS_tdata};
    assign acc_sum   = acc_q + acc_in;
    assign mean_full = acc_sum >>> shift;
    assign cnt_inc   = cnt_q + CntW'(1);
    assign blk_len   = CntW'(1) << shift;
    assign active    = en && !clr;
    assign restart   = (sel_status != sel_q) || shift_chg;
    // The mean of W-bit samples always fits in W bits.
    assign unused_mean_hi = ^mean_full[ACC_WIDTH-1:W];

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tvalid_d = 1'b0;
        blk_d    = blk_q;
        case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (active) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // Disable/clear/restart take priority over a completing sample.
                if (!active) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (restart) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (S_AXIS_tvalid) begin
                    if (cnt_inc == blk_len) begin
                        tdata_d  = mean_full[W-1:0];
                        tvalid_d = 1'b1;
                        acc_d    = '0;
                        cnt_d    = '0;
                        blk_d    = blk_q + 16'd1;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            blk_d = '0;
        end
    end

    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            blk_q    <= '0;
            sel_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            blk_q    <= blk_d;
            sel_q    <= sel_status;
        end
    end

    assign M_AXIS_tdata  = tdata_q;
    assign M_AXIS_tvalid = tvalid_q;
    assign blk_count     = blk_q;

endmodule

// File: tb/tb_cfg_axis_decimate_avg.sv
// Randomized and directed bench for cfg_axis_decimate_avg against a sample-queue model.
module tb_cfg_axis_decimate_avg;

    logic          a_clk = 1'b0;
    logic          a_rst;
    logic [1023:0] cfg;
    logic          sel_status;
    logic [31:0]   S_AXIS_tdata;
    logic          S_AXIS_tvalid;
    logic [31:0]   M_AXIS_tdata;
    logic          M_AXIS_tvalid;
    logic [15:0]   blk_count;

    cfg_axis_decimate_avg #(
        .SRC_ADDR         (1),
        .CFG_WIDTH        (1024),
        .AXIS_TDATA_WIDTH (32),
        .MAX_SHIFT        (10),
        .ACC_WIDTH        (48)
    ) dut (
        .a_clk         (a_clk),
        .a_rst         (a_rst),
        .cfg           (cfg),
        .sel_status    (sel_status),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .blk_count     (blk_count)
    );

    always #5 a_clk = ~a_clk;

    int          n_vec = 0;
    int          n_err = 0;

    // Reference model: samples of the current block, block length and emitted count.
    longint      blk_q[$];
    int unsigned cur_shift  = 0;
    bit          cur_active = 1'b0;
    bit          sel_drv    = 1'b0;
    logic [31:0] last_mean  = '0;
    int unsigned model_blk  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint s, input longint n);
        longint qq;
        qq = s / n;
        if ((s % n != 0) && (s < 0)) qq = qq - 1;
        return qq;
    endfunction

    // One clock: drive inputs, predict, then check outputs 1 time unit after the edge.
    task automatic tick(input bit vld, input logic [31:0] data, input bit toggle);
        bit     exp_v;
        longint sum;
        exp_v = 1'b0;
        if (toggle) sel_drv = ~sel_drv;
        sel_status    = sel_drv;
        S_AXIS_tvalid = vld;
        S_AXIS_tdata  = data;
        if (cur_active) begin
            if (toggle) begin
                blk_q.delete();
            end else if (vld) begin
                blk_q.push_back(longint'($signed(data)));
                if (blk_q.size() == (1 << cur_shift)) begin
                    sum = 0;
                    foreach (blk_q[i]) sum += blk_q[i];
                    last_mean = 32'(floor_div(sum, longint'(1) << cur_shift));
                    exp_v     = 1'b1;
                    model_blk = (model_blk + 1) % 65536;
                    blk_q.delete();
                end
            end
        end
        @(posedge a_clk);
        #1;
        check_eq("tvalid", {31'b0, M_AXIS_tvalid}, {31'b0, exp_v});
        check_eq(exp_v ? "mean" : "hold", M_AXIS_tdata, last_mean);
    endtask

    task automatic set_cfg(input int unsigned sh, input bit en, input bit clr);
        int unsigned eff;
        bit          act;
        logic [3:0]  sh4;
        eff = (sh > 10) ? 10 : sh;
        act = en && !clr;
        if (!act || !cur_active || eff != cur_shift) blk_q.delete();
        cur_shift  = eff;
        cur_active = act;
        if (clr) model_blk = 0;
        sh4 = sh[3:0];
        // Neighbouring words and unused bits carry noise that must be ignored.
        for (int i = 0; i < 32; i++) cfg[i*32 +: 32] = $urandom;
        cfg[32 +: 4] = sh4;
        cfg[36]      = en;
        cfg[37]      = clr;
        repeat (4) tick(1'b0, 32'h0, 1'b0);
    endtask

    task automatic check_blk(input string tag);
        check_eq(tag, {16'b0, blk_count}, 32'(model_blk));
    endtask

    initial begin
        a_rst         = 1'b1;
        cfg           = '0;
        sel_status    = 1'b0;
        S_AXIS_tdata  = '0;
        S_AXIS_tvalid = 1'b0;
        repeat (2) @(posedge a_clk);
        #1;
        check_eq("rst_tvalid", {31'b0, M_AXIS_tvalid}, 32'h0);
        check_eq("rst_tdata", M_AXIS_tdata, 32'h0);
        check_eq("rst_blk", {16'b0, blk_count}, 32'h0);
        a_rst = 1'b0;

        // 1: shift=2, 1..4 continuous -> 2
        set_cfg(2, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) tick(1'b1, 32'(i), 1'b0);
        check_blk("t1_blk");

        // 2: negative samples with gaps -> floor(-5/4) = -2
        tick(1'b1, 32'hFFFF_FFFF, 1'b0);
        tick(1'b0, 32'h1234_5678, 1'b0);
        tick(1'b1, 32'hFFFF_FFFF, 1'b0);
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b0, 32'h0, 1'b0);
        tick(1'b1, 32'hFFFF_FFFF, 1'b0);
        tick(1'b1, 32'hFFFF_FFFE, 1'b0);
        check_blk("t2_blk");

        // 3: partial block discarded by a source toggle, toggle-cycle sample dropped
        set_cfg(3, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, 32'(7 + i), 1'b0);
        tick(1'b1, 32'd999, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b1, 32'd100, 1'b0);
        check_blk("t3_blk");

        // 4: shift=0 pass-through
        set_cfg(0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1, 32'(i), 1'b0);
        check_blk("t4_blk");

        // 5: shift clamps to 10, full-scale samples must not overflow
        set_cfg(15, 1'b1, 1'b0);
        for (int i = 0; i < 1024; i++) tick(1'b1, 32'h7FFF_FFFF, 1'b0);
        check_blk("t5_blk");

        // Randomized segments: data, valid gaps, source toggles
        for (int seg = 0; seg < 8; seg++) begin
            set_cfg($urandom_range(0, 4), 1'b1, 1'b0);
            for (int i = 0; i < 80; i++) begin
                tick($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 29) == 0);
            end
            check_blk("rnd_blk");
        end

        // Disable mid-block drops the partial block
        set_cfg(2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, $urandom, 1'b0);
        set_cfg(2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, $urandom, 1'b0);
        set_cfg(2, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, $urandom, 1'b0);
        check_blk("dis_blk");

        // 6: asynchronous reset mid-block, then a fresh block
        for (int i = 0; i < 3; i++) tick(1'b1, 32'd55, 1'b0);
        a_rst = 1'b1;
        #1;
        check_eq("arst_tvalid", {31'b0, M_AXIS_tvalid}, 32'h0);
        check_eq("arst_tdata", M_AXIS_tdata, 32'h0);
        check_eq("arst_blk", {16'b0, blk_count}, 32'h0);
        blk_q.delete();
        last_mean = '0;
        model_blk = 0;
        repeat (2) tick(1'b0, 32'h0, 1'b0);
        a_rst = 1'b0;
        repeat (4) tick(1'b0, 32'h0, 1'b0);
        tick(1'b1, 32'd10, 1'b0);
        tick(1'b1, 32'hFFFF_FFF6, 1'b0);
        tick(1'b1, 32'd21, 1'b0);
        tick(1'b1, 32'd3, 1'b0);
        check_blk("t6_blk");

        // Clear zeroes the block counter and holds it
        set_cfg(0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, $urandom, 1'b0);
        check_blk("pre_clr_blk");
        set_cfg(0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, $urandom, 1'b0);
        check_blk("clr_blk");
        set_cfg(1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1, $urandom, 1'b0);
        check_blk("post_clr_blk");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
